// File: rtl/muldiv_sequencer_if.sv
// rtl/muldiv_sequencer_if.sv - request/result bundle between execute stage and the RV32M sequencer
interface muldiv_sequencer_if #(
    parameter int XLEN = 32
);
    logic            i_start;
    logic [2:0]      i_funct3;
    logic [XLEN-1:0] i_operand_a;
    logic [XLEN-1:0] i_operand_b;
    logic            i_flush;
    logic            o_busy;
    logic            o_stall;
    logic            o_done;
    logic [XLEN-1:0] o_result;

    modport master (
        output i_start, i_funct3, i_operand_a, i_operand_b, i_flush,
        input  o_busy, o_stall, o_done, o_result
    );

    modport slave (
        input  i_start, i_funct3, i_operand_a, i_operand_b, i_flush,
        output o_busy, o_stall, o_done, o_result
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - iterative RV32M multiply/divide sequencer (shift-add multiply, restoring divide)
// Optional MULDIV_FASTPATH_EN: div-by-zero and overflow skip RUN and finish in 3 cycles.
module muldiv_sequencer #(
    parameter int XLEN = 32
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    muldiv_sequencer_if.slave bus
);
    localparam int CW = $clog2(XLEN) + 1;

    typedef enum logic [2:0] {S_IDLE, S_PREP, S_RUN, S_FIX, S_DONE} state_t;

    state_t            r_state, w_next;
    logic [2:0]        r_op;
    logic [XLEN-1:0]   r_a, r_b, r_d;
    logic [2*XLEN-1:0] r_acc;
    logic [CW-1:0]     r_cnt;
    logic              r_neg, r_dz, r_ovf, r_done;
    logic [XLEN-1:0]   r_result;

    logic              w_accept, w_is_div, w_sa, w_sb, w_a_neg, w_b_neg, w_dz, w_ovf, w_ok;
    logic [XLEN-1:0]   w_a_abs, w_b_abs, w_dv, w_dvs, w_fix;
    logic [XLEN:0]     w_msum, w_rsh, w_sub;
    logic [2*XLEN-1:0] w_prod;

    assign w_accept = (r_state == S_IDLE) & bus.i_start & ~bus.i_flush;
    assign w_is_div = r_op[2];
    assign w_sa     = (r_op == 3'b001) | (r_op == 3'b010) | (r_op == 3'b100) | (r_op == 3'b110);
    assign w_sb     = (r_op == 3'b001) | (r_op == 3'b100) | (r_op == 3'b110);
    assign w_a_neg  = w_sa & r_a[XLEN-1];
    assign w_b_neg  = w_sb & r_b[XLEN-1];
    assign w_a_abs  = w_a_neg ? -r_a : r_a;
    assign w_b_abs  = w_b_neg ? -r_b : r_b;
    assign w_dz     = w_is_div & (r_b == '0);
    assign w_ovf    = w_is_div & ~r_op[0] & (r_a == {1'b1, {(XLEN-1){1'b0}}}) & (r_b == '1);

    // Multiply: r_acc low half holds the shrinking multiplier, r_d the multiplicand.
    assign w_msum   = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_d} : '0);
    // Divide: {rem, quo} in r_acc; the shifted remainder needs one extra bit before the trial subtract.
    assign w_rsh    = r_acc[2*XLEN-1:XLEN-1];
    assign w_sub    = {1'b0, w_rsh[XLEN-1:0]} - {1'b0, r_d};
    assign w_ok     = w_rsh[XLEN] | ~w_sub[XLEN];

    assign w_prod   = r_neg ? -r_acc : r_acc;
    assign w_dv     = r_op[1] ? r_acc[2*XLEN-1:XLEN] : r_acc[XLEN-1:0];
    assign w_dvs    = r_neg ? -w_dv : w_dv;

    always_comb begin
        w_fix = w_dvs;
        if (!w_is_div)
            w_fix = (r_op == 3'b000) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
        else if (r_dz)
            w_fix = r_op[1] ? r_a : '1;
        else if (r_ovf)
            w_fix = r_op[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_next = S_PREP;
`ifdef MULDIV_FASTPATH_EN
            S_PREP: w_next = (w_dz | w_ovf) ? S_FIX : S_RUN;
`else
            S_PREP: w_next = S_RUN;
`endif
            S_RUN:  if (r_cnt == CW'(XLEN - 1)) w_next = S_FIX;
            S_FIX:  w_next = S_DONE;
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (bus.i_flush) w_next = S_IDLE;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_op     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_d      <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_neg    <= 1'b0;
            r_dz     <= 1'b0;
            r_ovf    <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
        end else begin
            r_done <= (r_state == S_FIX) & ~bus.i_flush;
            case (r_state)
                S_IDLE: if (w_accept) begin
                    r_op <= bus.i_funct3;
                    r_a  <= bus.i_operand_a;
                    r_b  <= bus.i_operand_b;
                end
                S_PREP: begin
                    r_d   <= w_is_div ? w_b_abs : w_a_abs;
                    r_acc <= {{XLEN{1'b0}}, (w_is_div ? w_a_abs : w_b_abs)};
                    r_cnt <= '0;
                    r_neg <= (r_op == 3'b110) ? w_a_neg : (w_a_neg ^ w_b_neg);
                    r_dz  <= w_dz;
                    r_ovf <= w_ovf;
                end
                S_RUN: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (!w_is_div)
                        r_acc <= {w_msum, r_acc[XLEN-1:1]};
                    else if (w_ok)
                        r_acc <= {w_sub[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
                    else
                        r_acc <= {w_rsh[XLEN-1:0], r_acc[XLEN-2:0], 1'b0};
                end
                S_FIX: if (!bus.i_flush) r_result <= w_fix;
                default: ;
            endcase
        end
    end

    assign bus.o_busy   = (r_state != S_IDLE);
    assign bus.o_stall  = w_accept | (r_state == S_PREP) | (r_state == S_RUN) | (r_state == S_FIX);
    assign bus.o_done   = r_done;
    assign bus.o_result = r_result;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb/tb_muldiv_sequencer.sv - scoreboard bench for muldiv_sequencer with directed RV32M vectors
module tb_muldiv_sequencer;
    localparam int XLEN = 32;
`ifdef MULDIV_FASTPATH_EN
    localparam bit FP = 1'b1;
`else
    localparam bit FP = 1'b0;
`endif

    typedef struct {
        logic [31:0] res;
        int          lat;
        string       name;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   t_issue = 0;
    logic [31:0] last_res = 32'h0;
    exp_t sb[$];
    exp_t m_e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    muldiv_sequencer_if #(.XLEN(XLEN)) bus();
    muldiv_sequencer #(.XLEN(XLEN)) dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.o_done === 1'b1) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got done=1 want done=0 (cycle %0d)", cyc);
            end else begin
                m_e = sb.pop_front();
                check({m_e.name, "_result"}, bus.o_result, m_e.res);
                check({m_e.name, "_latency"}, 32'(cyc - t_issue), 32'(m_e.lat));
            end
        end
    end

    task automatic issue(input string name, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] res, input bit special,
                         input bit expect_done);
        @(posedge clk); #1;
        bus.i_start = 1'b1;
        bus.i_funct3 = f;
        bus.i_operand_a = a;
        bus.i_operand_b = b;
        t_issue = cyc;
        if (expect_done) begin
            sb.push_back('{res, (special && FP) ? 3 : 35, name});
            last_res = res;
        end
    endtask

    task automatic release_start();
        @(posedge clk); #1;
        bus.i_start = 1'b0;
        bus.i_funct3 = ~bus.i_funct3;
        bus.i_operand_a = ~bus.i_operand_a;
        bus.i_operand_b = 32'h1234_5678;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((sb.size() != 0 || bus.o_busy) && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        if (sb.size() != 0 || bus.o_busy) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: got busy=%0b pending=%0d want idle", name, bus.o_busy, sb.size());
            sb.delete();
        end
    endtask

    task automatic run(input string name, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] res, input bit special);
        issue(name, f, a, b, res, special, 1'b1);
        release_start();
        wait_idle(name);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.i_start = 1'b0;
        bus.i_funct3 = 3'b0;
        bus.i_operand_a = 32'h0;
        bus.i_operand_b = 32'h0;
        bus.i_flush = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {31'b0, bus.o_busy}, 32'h0);
        check("rst_stall", {31'b0, bus.o_stall}, 32'h0);
        check("rst_done", {31'b0, bus.o_done}, 32'h0);
        check("rst_result", bus.o_result, 32'h0);
        rst_n = 1'b1;

        // MUL with cycle-by-cycle stall profile
        issue("mul", 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, 1'b1);
        for (int k = 0; k <= 35; k++) begin
            @(negedge clk);
            check($sformatf("mul_stall_c%0d", k), {31'b0, bus.o_stall}, 32'(k <= 34));
            @(posedge clk); #1;
            if (k == 0) begin
                bus.i_start = 1'b0;
                bus.i_operand_a = 32'h0;
            end
        end
        wait_idle("mul");

        run("mulhu",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
        run("mulh",   3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0);
        run("mulhsu", 3'b010, 32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 1'b0);
        run("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
        run("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
        run("div_m7",  3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 1'b0);
        run("rem_m7",  3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 1'b0);
        run("divu_z",  3'b101, 32'd100,       32'd0,         32'hFFFF_FFFF, 1'b1);
        run("remu_z",  3'b111, 32'd100,       32'd0,         32'd100,       1'b1);
        run("divu",    3'b101, 32'd100,       32'd7,         32'd14,        1'b0);
        run("remu",    3'b111, 32'd100,       32'd7,         32'd2,         1'b0);

        // Second start in cycle 5 must be dropped
        issue("dbl", 3'b000, 32'd5, 32'd6, 32'd30, 1'b0, 1'b1);
        release_start();
        repeat (4) begin @(posedge clk); #1; end
        bus.i_start = 1'b1;
        bus.i_funct3 = 3'b101;
        bus.i_operand_a = 32'd9;
        bus.i_operand_b = 32'd2;
        @(posedge clk); #1;
        bus.i_start = 1'b0;
        check("dbl_busy_c6", {31'b0, bus.o_busy}, 32'h1);
        wait_idle("dbl");
        repeat (40) @(posedge clk);
        #1;

        // Flush in cycle 10 aborts without done
        issue("flush", 3'b101, 32'd1000, 32'd3, 32'd0, 1'b0, 1'b0);
        release_start();
        repeat (9) begin @(posedge clk); #1; end
        bus.i_flush = 1'b1;
        @(posedge clk); #1;
        bus.i_flush = 1'b0;
        check("flush_busy_c11", {31'b0, bus.o_busy}, 32'h0);
        check("flush_result_c11", bus.o_result, last_res);
        repeat (45) @(posedge clk);
        #1;
        check("flush_result_late", bus.o_result, last_res);

        // Asynchronous reset in cycle 20
        issue("rst", 3'b000, 32'd9, 32'd9, 32'd0, 1'b0, 1'b0);
        release_start();
        repeat (19) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        check("arst_busy", {31'b0, bus.o_busy}, 32'h0);
        check("arst_stall", {31'b0, bus.o_stall}, 32'h0);
        check("arst_done", {31'b0, bus.o_done}, 32'h0);
        check("arst_result", bus.o_result, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        run("mul3x4", 3'b000, 32'd3, 32'd4, 32'd12, 1'b0);
        repeat (5) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
